// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - shared state encoding and sizing helpers for the DVP source
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        HBLANK,
        VFP
    } dvp_state_e;

    // First byte of each pixel on the bus is the high byte (R + upper G).
    localparam bit HI_FIRST = 1'b1;

    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// rtl/dvp_tx_timing.sv - frame/line timing FSM with byte, line and blank counters
module dvp_tx_timing
    import dvp_pkg::*;
#(
    parameter int IMG_W   = 200,
    parameter int IMG_H   = 164,
    parameter int H_BLANK = 32,
    parameter int VSYNC_W = 64,
    parameter int V_BP    = 128,
    parameter int V_FP    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output dvp_state_e state_o,
    output logic       phase_o
);

    localparam int BCW = cnt_width(2 * IMG_W);
    localparam int LW  = cnt_width(IMG_H);
    localparam int BW  = cnt_width(max2(max2(H_BLANK, VSYNC_W), max2(V_BP, V_FP)));

    localparam logic [BCW-1:0] BYTE_LAST  = BCW'(2 * IMG_W - 1);
    localparam logic [LW-1:0]  LINE_LAST  = LW'(IMG_H - 1);
    localparam logic [BW-1:0]  VSYNC_LAST = BW'(VSYNC_W - 1);
    localparam logic [BW-1:0]  VBP_LAST   = BW'(V_BP - 1);
    localparam logic [BW-1:0]  HB_LAST    = BW'(H_BLANK - 1);
    localparam logic [BW-1:0]  VFP_LAST   = BW'(V_FP - 1);

    dvp_state_e     state_q;
    logic [BCW-1:0] byte_q;
    logic [LW-1:0]  line_q;
    logic [BW-1:0]  blank_q;

    // Blanking states share one counter; every counter returns to 0 when its state exits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            byte_q  <= '0;
            line_q  <= '0;
            blank_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) state_q <= VSYNC;
                end
                VSYNC: begin
                    if (blank_q == VSYNC_LAST) begin
                        blank_q <= '0;
                        state_q <= VBP;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                VBP: begin
                    if (blank_q == VBP_LAST) begin
                        blank_q <= '0;
                        state_q <= ACTIVE;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (byte_q == BYTE_LAST) begin
                        byte_q  <= '0;
                        state_q <= HBLANK;
                    end else begin
                        byte_q <= byte_q + 1'b1;
                    end
                end
                HBLANK: begin
                    if (blank_q == HB_LAST) begin
                        blank_q <= '0;
                        if (line_q == LINE_LAST) begin
                            line_q  <= '0;
                            state_q <= VFP;
                        end else begin
                            line_q  <= line_q + 1'b1;
                            state_q <= ACTIVE;
                        end
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                VFP: begin
                    if (blank_q == VFP_LAST) begin
                        blank_q <= '0;
                        state_q <= en ? VSYNC : IDLE;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o = state_q;
    assign phase_o = byte_q[0];

endmodule

// File: rtl/dvp_tx.sv
// rtl/dvp_tx.sv - DVP camera-side source: RGB565 pixel stream to vsync/href/8-bit bus
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int IMG_W   = 200,
    parameter int IMG_H   = 164,
    parameter int H_BLANK = 32,
    parameter int VSYNC_W = 64,
    parameter int V_BP    = 128,
    parameter int V_FP    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        underrun
);

    dvp_state_e state;
    logic       phase;

    dvp_tx_timing #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .H_BLANK(H_BLANK),
        .VSYNC_W(VSYNC_W),
        .V_BP   (V_BP),
        .V_FP   (V_FP)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .state_o(state),
        .phase_o(phase)
    );

    logic [15:0] pix_cap;
    logic [7:0]  first_byte, second_byte;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic        fs_q, fs_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  second_q, second_d;
    logic        und_q, und_d;

    assign pix_ready   = (state == ACTIVE) && !phase;
    assign pix_cap     = pix_valid ? pix_data : 16'h0000;
    assign first_byte  = HI_FIRST ? pix_cap[15:8] : pix_cap[7:0];
    assign second_byte = HI_FIRST ? pix_cap[7:0]  : pix_cap[15:8];

    // First byte goes straight to the bus register; the second waits one cycle in second_q.
    always_comb begin
        vsync_d  = (state == VSYNC);
        href_d   = (state == ACTIVE);
        fs_d     = vsync_d && !vsync_q;
        data_d   = 8'h00;
        second_d = second_q;
        und_d    = und_q;
        if (pix_ready) begin
            data_d   = first_byte;
            second_d = second_byte;
            if (!pix_valid) und_d = 1'b1;
        end else if (href_d) begin
            data_d = second_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            fs_q     <= 1'b0;
            data_q   <= 8'h00;
            second_q <= 8'h00;
            und_q    <= 1'b0;
        end else begin
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            fs_q     <= fs_d;
            data_q   <= data_d;
            second_q <= second_d;
            und_q    <= und_d;
        end
    end

    assign cam_vsync   = vsync_q;
    assign cam_href    = href_q;
    assign cam_data    = data_q;
    assign frame_start = fs_q;
    assign underrun    = und_q;

endmodule

// File: tb/tb_dvp_tx.sv
// tb/tb_dvp_tx.sv - randomized scoreboard bench for dvp_tx against a frame-timing model
module tb_dvp_tx;

    localparam int IMG_W    = 4;
    localparam int IMG_H    = 3;
    localparam int H_BLANK  = 6;
    localparam int VSYNC_W  = 8;
    localparam int V_BP     = 10;
    localparam int V_FP     = 5;
    localparam int LINE_LEN = 2 * IMG_W + H_BLANK;
    localparam int ACT0     = VSYNC_W + V_BP;
    localparam int PERIOD   = ACT0 + IMG_H * LINE_LEN + V_FP;
    localparam int NSLOT    = 512;
    localparam int NEVER    = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_valid = 1'b0;
    logic        pix_ready, cam_vsync, cam_href, frame_start, underrun;
    logic [7:0]  cam_data;

    dvp_tx #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .H_BLANK(H_BLANK),
        .VSYNC_W(VSYNC_W), .V_BP(V_BP), .V_FP(V_FP)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    logic        en_e = 1'b0;
    logic        rst_e = 1'b1;
    logic [15:0] src_data[NSLOT];
    bit          src_valid[NSLOT];
    bit          init_done = 1'b0;
    logic [7:0]  sb_q[$];
    int          und_edge = NEVER;
    bit          running = 1'b0;
    int          frame_t0 = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Output position p counts cycles from the first vsync-high output cycle of a frame.
    function automatic bit href_at(input int p);
        int q = p - ACT0;
        return (q >= 0) && (q < IMG_H * LINE_LEN) && ((q % LINE_LEN) < 2 * IMG_W);
    endfunction

    function automatic bit ready_at(input int p);
        int q = p - ACT0;
        return href_at(p) && (((q % LINE_LEN) % 2) == 0);
    endfunction

    always @(posedge clk) begin
        ncyc++;
        en_e  = en;
        rst_e = rst;
    end

    // Source: presents one slot at a time, pushes expected bytes when the DUT takes it.
    initial begin : driver
        int  slot;
        bit  consumed;
        slot = 0;
        wait (init_done);
        forever begin
            pix_data  = src_data[slot % NSLOT];
            pix_valid = src_valid[slot % NSLOT];
            @(negedge clk);
            consumed = 1'b0;
            if (pix_ready && !rst) begin
                sb_q.push_back(pix_valid ? pix_data[15:8] : 8'h00);
                sb_q.push_back(pix_valid ? pix_data[7:0]  : 8'h00);
                if (!pix_valid && und_edge > ncyc + 1) und_edge = ncyc + 1;
                consumed = 1'b1;
            end
            @(posedge clk);
            #1;
            if (consumed) slot++;
        end
    end

    // Monitor: advances the frame model one output cycle and compares every output.
    always @(negedge clk) begin
        bit ev, eh, ef, er;
        int p;
        ev = 1'b0; eh = 1'b0; ef = 1'b0; er = 1'b0;
        if (rst || rst_e) begin
            running  = 1'b0;
            und_edge = NEVER;
            sb_q.delete();
        end else begin
            if (running) begin
                p  = ncyc - frame_t0;
                ev = (p < VSYNC_W);
                ef = (p == 0);
                eh = href_at(p);
                if (p == PERIOD - 1) begin
                    if (en_e) frame_t0 = ncyc + 1;
                    else running = 1'b0;
                end
            end else if (en_e) begin
                running  = 1'b1;
                frame_t0 = ncyc + 1;
            end
            if (running) er = ready_at(ncyc + 1 - frame_t0);
        end
        check("cam_vsync", {15'd0, cam_vsync}, {15'd0, ev});
        check("cam_href", {15'd0, cam_href}, {15'd0, eh});
        check("frame_start", {15'd0, frame_start}, {15'd0, ef});
        check("pix_ready", {15'd0, pix_ready}, {15'd0, er});
        check("underrun", {15'd0, underrun}, {15'd0, (und_edge <= ncyc)});
        if (cam_href) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cam_data_extra: got %h with href but expected no byte (cycle %0d)", cam_data, ncyc);
            end else begin
                check("cam_data", {8'd0, cam_data}, {8'd0, sb_q.pop_front()});
            end
        end else begin
            check("cam_data_idle", {8'd0, cam_data}, 16'h0000);
        end
    end

    initial begin : main
        int b;
        for (int i = 0; i < NSLOT; i++) begin
            src_data[i]  = 16'($urandom);
            src_valid[i] = (i >= 24) ? ($urandom_range(0, 7) != 0) : (i != 6);
        end
        src_data[0] = 16'hF800;
        src_data[1] = 16'h07E0;
        src_data[2] = 16'h001F;
        src_data[3] = 16'hABCD;
        init_done = 1'b1;

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;

        // Drop en partway through line 1 of the third frame; that frame must still complete.
        repeat (170) @(posedge clk);
        #1 en = 1'b0;
        repeat (90) @(posedge clk);
        #1 en = 1'b1;

        b = 0;
        while (!cam_href && b < 200) begin
            @(negedge clk);
            b++;
        end
        checks++;
        if (b >= 200) begin
            errors++;
            $display("FAIL href_wait: got no href within %0d cycles, required href", b);
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_vsync", {15'd0, cam_vsync}, 16'h0000);
        check("rst_href", {15'd0, cam_href}, 16'h0000);
        check("rst_data", {8'd0, cam_data}, 16'h0000);
        check("rst_ready", {15'd0, pix_ready}, 16'h0000);
        check("rst_underrun", {15'd0, underrun}, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        repeat (PERIOD + 30) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
